panel_switch_reader: RTL and testbench

Input-side companion to the lamp driver: samples the 11 raw front-panel switch inputs and synchronizes them to `clock`. Debounces each switch independently and presents clean levels. Queues press/release events through a valid/ready handshake to the panel controller. It sits between the board pins and the control logic that decides lamp states.

---
 rtl/panel_pkg.sv | 17 +
 rtl/sw_debounce_cell.sv | 53 +++++
 rtl/panel_switch_reader.sv | 136 +++++++++++++
 tb/tb_panel_switch_reader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/panel_pkg.sv
// rtl/panel_pkg.sv - shared constants and event type for the panel switch reader
//   N_SW_DEFAULT   : default number of front-panel switches
//   SW_IDX_W       : width of a switch index carried in an event
//   SW_RESET_LEVEL : level loaded into synchronizers and debounced outputs at reset
//   sw_evt_t       : one queued event {index, press}
package panel_pkg;

   localparam int   N_SW_DEFAULT   = 11;
   localparam int   SW_IDX_W       = 4;
   localparam logic SW_RESET_LEVEL = 1'b0;

   typedef struct packed {
      logic [SW_IDX_W-1:0] index;
      logic                press;
   } sw_evt_t;

endpackage

// File: rtl/sw_debounce_cell.sv
// rtl/sw_debounce_cell.sv - synchronizer, debounce counter and stable flop for one switch
//   clock     in  : rising-edge clock
//   reset_n   in  : asynchronous active-low reset
//   sw_raw    in  : asynchronous switch pin, 1 = pressed
//   sw_stable out : debounced level
//   flip      out : high in the cycle whose closing edge changes sw_stable
//   rising    out : direction of that change (1 = 0->1), valid while flip is high
module sw_debounce_cell
   import panel_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic clock,
   input  logic reset_n,
   input  logic sw_raw,
   output logic sw_stable,
   output logic flip,
   output logic rising
);

   localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;

   // The new level is whatever the synchronizer holds when the count expires.
   assign flip   = (sync2 != sw_stable) && (cnt == CNT_MAX);
   assign rising = sync2;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1     <= SW_RESET_LEVEL;
         sync2     <= SW_RESET_LEVEL;
         sw_stable <= SW_RESET_LEVEL;
         cnt       <= '0;
      end else begin
         sync1 <= sw_raw;
         sync2 <= sync1;
         // Any return to the accepted level restarts the count.
         if (sync2 == sw_stable) begin
            cnt <= '0;
         end else if (flip) begin
            cnt       <= '0;
            sw_stable <= sync2;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/panel_switch_reader.sv
// rtl/panel_switch_reader.sv - debounced front-panel switch reader with press/release event queue
//   Optional feature macro: PANEL_SW_RELEASE_EVT_EN (queue release events as well as presses)
//   clock        in  : rising-edge clock
//   reset_n      in  : asynchronous active-low reset
//   sw_raw       in  : N_SW asynchronous switch pins, 1 = pressed
//   sw_stable    out : N_SW debounced levels
//   evt_valid    out : FIFO head holds an event
//   evt_ready    in  : consumer accepts the head event when evt_valid is high
//   evt_index    out : switch number of the head event (0 when empty)
//   evt_press    out : 1 = press, 0 = release (0 when empty)
//   evt_overflow out : sticky, an event was overwritten before it could be queued
//   Parameters: N_SW (<=16), DEBOUNCE_CYCLES (>=2), EVT_DEPTH (power of two, >=2)
module panel_switch_reader
   import panel_pkg::*;
#(
   parameter int N_SW            = N_SW_DEFAULT,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int EVT_DEPTH       = 4
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [N_SW-1:0]     sw_raw,
   output logic [N_SW-1:0]     sw_stable,
   output logic                evt_valid,
   input  logic                evt_ready,
   output logic [SW_IDX_W-1:0] evt_index,
   output logic                evt_press,
   output logic                evt_overflow
);

   localparam int PTR_W = $clog2(EVT_DEPTH);

   logic [N_SW-1:0]  flip;
   logic [N_SW-1:0]  rising;
   logic [N_SW-1:0]  accept;
   logic [N_SW-1:0]  pend;
   logic [N_SW-1:0]  pend_type;
   logic [N_SW-1:0]  grant;
   logic [N_SW-1:0]  clr;
   logic             any_pend;
   sw_evt_t          new_evt;
   sw_evt_t          head;
   sw_evt_t          mem [EVT_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             full;
   logic             push;
   logic             pop;

   for (genvar i = 0; i < N_SW; i++) begin : g_cell
      sw_debounce_cell #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_cell (
         .clock     (clock),
         .reset_n   (reset_n),
         .sw_raw    (sw_raw[i]),
         .sw_stable (sw_stable[i]),
         .flip      (flip[i]),
         .rising    (rising[i])
      );
   end

   // Level changes that become events; filtered releases only move sw_stable.
`ifdef PANEL_SW_RELEASE_EVT_EN
   assign accept = flip;
`else
   assign accept = flip & rising;
`endif

   // Lowest-index pending switch wins.
   always_comb begin
      grant    = '0;
      any_pend = 1'b0;
      new_evt  = '0;
      for (int i = 0; i < N_SW; i++) begin
         if (pend[i] && !any_pend) begin
            any_pend      = 1'b1;
            grant[i]      = 1'b1;
            new_evt.index = SW_IDX_W'(i);
            new_evt.press = pend_type[i];
         end
      end
   end

   assign full  = (count == (PTR_W + 1)'(EVT_DEPTH));
   assign pop   = evt_valid && evt_ready;
   // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
   assign push  = any_pend && (!full || pop);
   assign clr   = push ? grant : '0;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pend         <= '0;
         pend_type    <= '0;
         evt_overflow <= 1'b0;
      end else begin
         pend      <= (pend & ~clr) | accept;
         pend_type <= (pend_type & ~accept) | (rising & accept);
         // A bit being pushed this cycle is no longer occupied, so a new flip there loses nothing.
         if (|(accept & pend & ~clr)) begin
            evt_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < EVT_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= new_evt;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            count <= count + (PTR_W + 1)'(1);
         end else if (pop && !push) begin
            count <= count - (PTR_W + 1)'(1);
         end
      end
   end

   assign head      = mem[rd_ptr];
   assign evt_valid = (count != '0);
   assign evt_index = evt_valid ? head.index : '0;
   assign evt_press = evt_valid ? head.press : 1'b0;

endmodule

// File: tb/tb_panel_switch_reader.sv
// tb/tb_panel_switch_reader.sv - self-checking bench for panel_switch_reader
module tb_panel_switch_reader;

   logic        clock   = 1'b0;
   logic        reset_n = 1'b0;
   logic [10:0] sw_raw  = '0;
   logic        evt_ready = 1'b0;
   logic [10:0] sw_stable;
   logic        evt_valid;
   logic [3:0]  evt_index;
   logic        evt_press;
   logic        evt_overflow;

   int checks = 0;
   int errors = 0;

`ifdef PANEL_SW_RELEASE_EVT_EN
   localparam logic REL_EN = 1'b1;
`else
   localparam logic REL_EN = 1'b0;
`endif

   typedef struct packed {
      logic [10:0] raw;
      logic        ready;
      logic [7:0]  cycles;
      logic [10:0] exp_stable;
      logic        exp_valid;
      logic [3:0]  exp_idx;
      logic        exp_press;
   } vec_t;

   vec_t vecs [9];

   always #5 clock = ~clock;

   panel_switch_reader #(
      .N_SW            (11),
      .DEBOUNCE_CYCLES (8),
      .EVT_DEPTH       (4)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .sw_raw       (sw_raw),
      .sw_stable    (sw_stable),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_index    (evt_index),
      .evt_press    (evt_press),
      .evt_overflow (evt_overflow)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic chk_evt(input string name, input logic v, input logic [3:0] idx, input logic p);
      chk({name, ".valid"}, {31'd0, evt_valid}, {31'd0, v});
      chk({name, ".index"}, {28'd0, evt_index}, {28'd0, idx});
      chk({name, ".press"}, {31'd0, evt_press}, {31'd0, p});
   endtask

   task automatic settle();
      sw_raw    = '0;
      evt_ready = 1'b1;
      ticks(24);
      evt_ready = 1'b0;
   endtask

   function automatic vec_t mkvec(input logic [10:0] raw, input logic rdy, input int cyc,
                                  input logic [10:0] st, input logic v, input logic [3:0] idx,
                                  input logic p);
      vec_t r;
      r.raw        = raw;
      r.ready      = rdy;
      r.cycles     = 8'(cyc);
      r.exp_stable = st;
      r.exp_valid  = v;
      r.exp_idx    = idx;
      r.exp_press  = p;
      return r;
   endfunction

   initial begin
      int glitch_bad;

      // Clean press then release of switch 5, edge numbers counted from the raw change.
      vecs[0] = mkvec(11'h020, 1'b0, 9, 11'h000, 1'b0, 4'd0, 1'b0);
      vecs[1] = mkvec(11'h020, 1'b0, 1, 11'h020, 1'b0, 4'd0, 1'b0);
      vecs[2] = mkvec(11'h020, 1'b0, 1, 11'h020, 1'b1, 4'd5, 1'b1);
      vecs[3] = mkvec(11'h020, 1'b0, 3, 11'h020, 1'b1, 4'd5, 1'b1);
      vecs[4] = mkvec(11'h020, 1'b1, 1, 11'h020, 1'b0, 4'd0, 1'b0);
      vecs[5] = mkvec(11'h000, 1'b0, 9, 11'h020, 1'b0, 4'd0, 1'b0);
      vecs[6] = mkvec(11'h000, 1'b0, 1, 11'h000, 1'b0, 4'd0, 1'b0);
      vecs[7] = mkvec(11'h000, 1'b0, 1, 11'h000, REL_EN, REL_EN ? 4'd5 : 4'd0, 1'b0);
      vecs[8] = mkvec(11'h000, 1'b1, 1, 11'h000, 1'b0, 4'd0, 1'b0);

      // Reset state
      ticks(3);
      chk_evt("reset", 1'b0, 4'd0, 1'b0);
      chk("reset.overflow", {31'd0, evt_overflow}, 32'd0);
      chk("reset.stable", {21'd0, sw_stable}, 32'd0);
      reset_n = 1'b1;

      for (int v = 0; v < 9; v++) begin
         sw_raw    = vecs[v].raw;
         evt_ready = vecs[v].ready;
         ticks(int'(vecs[v].cycles));
         chk($sformatf("vec%0d.stable", v), {21'd0, sw_stable}, {21'd0, vecs[v].exp_stable});
         chk_evt($sformatf("vec%0d", v), vecs[v].exp_valid, vecs[v].exp_idx, vecs[v].exp_press);
      end
      evt_ready = 1'b0;

      // Bounce on switch 2: only the final 0->1 counts.
      sw_raw[2] = 1'b1; tick();
      sw_raw[2] = 1'b0; tick();
      sw_raw[2] = 1'b1; tick();
      sw_raw[2] = 1'b0; tick();
      sw_raw[2] = 1'b1;
      ticks(9);
      chk("bounce.stable_early", {31'd0, sw_stable[2]}, 32'd0);
      tick();
      chk("bounce.stable", {31'd0, sw_stable[2]}, 32'd1);
      chk("bounce.no_evt_yet", {31'd0, evt_valid}, 32'd0);
      tick();
      chk_evt("bounce.evt", 1'b1, 4'd2, 1'b1);
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      chk("bounce.popped", {31'd0, evt_valid}, 32'd0);
      ticks(10);
      chk("bounce.single", {31'd0, evt_valid}, 32'd0);

      // 7-cycle low glitch on switch 2 must not move the debounced level.
      glitch_bad = 0;
      sw_raw[2] = 1'b0;
      for (int k = 0; k < 7; k++) begin
         tick();
         if (sw_stable[2] !== 1'b1 || evt_valid !== 1'b0) glitch_bad++;
      end
      sw_raw[2] = 1'b1;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (sw_stable[2] !== 1'b1 || evt_valid !== 1'b0) glitch_bad++;
      end
      chk("glitch.bad_cycles", glitch_bad, 32'd0);
      settle();

      // Simultaneous flips on switches 3 and 7, consumer always ready.
      evt_ready = 1'b1;
      sw_raw    = 11'h088;
      ticks(10);
      chk("simul.stable", {21'd0, sw_stable}, 32'h088);
      chk("simul.no_evt", {31'd0, evt_valid}, 32'd0);
      tick();
      chk_evt("simul.first", 1'b1, 4'd3, 1'b1);
      tick();
      chk_evt("simul.second", 1'b1, 4'd7, 1'b1);
      tick();
      chk("simul.empty", {31'd0, evt_valid}, 32'd0);
      evt_ready = 1'b0;
      settle();

      // Backpressure: five presses into a four-deep FIFO, then overwrite switch 4.
      sw_raw = 11'h01F;
      ticks(19);
      chk_evt("bp.head", 1'b1, 4'd0, 1'b1);
      chk("bp.stable", {21'd0, sw_stable}, 32'h01F);
      chk("bp.overflow0", {31'd0, evt_overflow}, 32'd0);
      sw_raw[4] = 1'b0;
      ticks(12);
      chk("bp.rel_stable", {21'd0, sw_stable}, 32'h00F);
      chk("bp.rel_overflow", {31'd0, evt_overflow}, {31'd0, REL_EN});
      sw_raw[4] = 1'b1;
      ticks(12);
      chk("bp.repress_stable", {21'd0, sw_stable}, 32'h01F);
      chk("bp.overflow", {31'd0, evt_overflow}, 32'd1);
      evt_ready = 1'b1;
      for (int j = 0; j < 5; j++) begin
         chk_evt($sformatf("bp.drain%0d", j), 1'b1, 4'(j), 1'b1);
         tick();
      end
      chk("bp.drained", {31'd0, evt_valid}, 32'd0);
      evt_ready = 1'b0;
      chk("bp.overflow_sticky", {31'd0, evt_overflow}, 32'd1);
      settle();

      // Release filter on switch 9.
      sw_raw[9] = 1'b1;
      ticks(12);
      chk_evt("filt.press", 1'b1, 4'd9, 1'b1);
      sw_raw[9] = 1'b0;
      ticks(12);
      chk_evt("filt.head_hold", 1'b1, 4'd9, 1'b1);
      evt_ready = 1'b1;
      tick();
      if (REL_EN) begin
         chk_evt("filt.release", 1'b1, 4'd9, 1'b0);
         tick();
      end
      chk("filt.empty", {31'd0, evt_valid}, 32'd0);
      evt_ready = 1'b0;

      // Reset mid-operation with three events queued.
      sw_raw = 11'h007;
      ticks(14);
      chk_evt("rst.queued", 1'b1, 4'd0, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      chk_evt("rst.async", 1'b0, 4'd0, 1'b0);
      chk("rst.overflow", {31'd0, evt_overflow}, 32'd0);
      chk("rst.stable", {21'd0, sw_stable}, 32'd0);
      sw_raw = 11'h002;
      ticks(2);
      reset_n = 1'b1;
      ticks(10);
      chk("rst.stable_after", {21'd0, sw_stable}, 32'h002);
      chk("rst.no_evt_yet", {31'd0, evt_valid}, 32'd0);
      tick();
      chk_evt("rst.evt", 1'b1, 4'd1, 1'b1);
      evt_ready = 1'b1;
      tick();
      chk("rst.popped", {31'd0, evt_valid}, 32'd0);
      ticks(12);
      chk("rst.only_one", {31'd0, evt_valid}, 32'd0);
      evt_ready = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
